// File: rtl/np_update_scheduler_pkg.sv
// Shared types and constants for the NeoPixel update scheduler.
package np_sched_pkg;
  typedef enum logic [1:0] {IDLE, GO, DRAIN, WAIT} sched_state_t;

  localparam int NP_NUM_PIXELS = 8;
  localparam int PIX_W = $clog2(NP_NUM_PIXELS);
endpackage

// File: rtl/np_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping.
// The grant is gated by en; any reports raw request presence.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);
  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    any       = |req;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[PW'(idx)]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end
endmodule

// File: rtl/np_update_scheduler.sv
// Shares one 8-pixel NeoPixel controller between NUM_REQ requesters, batching
// loads and issuing one go per batch. Optional NPS_AUTO_REFRESH_EN re-sends idle frames.
module np_update_scheduler
  import np_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int MAX_BATCH      = 8,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][PIX_W-1:0]   req_pixel,
  input  logic [NUM_REQ-1:0][7:0]         req_red,
  input  logic [NUM_REQ-1:0][7:0]         req_green,
  input  logic [NUM_REQ-1:0][7:0]         req_blue,
  output logic [NUM_REQ-1:0]              req_ack,
  input  logic                            np_ready,
  output logic                            np_load,
  output logic                            np_go,
  output logic [PIX_W-1:0]                np_pixel,
  output logic [7:0]                      np_red,
  output logic [7:0]                      np_green,
  output logic [7:0]                      np_blue,
  output logic                            busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BATCH + 1);
  localparam logic [BW-1:0] BATCH_MAX = BW'(MAX_BATCH);

  if (NUM_REQ < 2 || NUM_REQ > 4 || MAX_BATCH < 1 || REFRESH_CYCLES < 2) begin : g_param_check
    $error("np_update_scheduler: parameter out of range");
  end

  sched_state_t      state_reg, state_next;
  logic [BW-1:0]     batch_cnt_reg;
  logic              dirty_reg;
  logic [PW-1:0]     rr_ptr_reg;
  logic              drain_first_reg;
  logic              load_en;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]     grant_idx;
  logic              any_valid;
  logic              refresh_hit;

  // Reset also gates the grant so every output reads 0 while it is held.
  assign load_en = !reset && (state_reg == IDLE) && np_ready && (batch_cnt_reg < BATCH_MAX);

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .en        (load_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_valid)
  );

  assign req_ack = grant;
  assign np_load = |grant;

  always_comb begin
    np_pixel = '0;
    np_red   = '0;
    np_green = '0;
    np_blue  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        np_pixel = np_pixel | req_pixel[i];
        np_red   = np_red   | req_red[i];
        np_green = np_green | req_green[i];
        np_blue  = np_blue  | req_blue[i];
      end
    end
  end

`ifdef NPS_AUTO_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  logic [RW-1:0] refresh_cnt_reg;

  assign refresh_hit = np_ready && !any_valid && !dirty_reg &&
                       (refresh_cnt_reg == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
    end else if (state_reg != IDLE || state_next != IDLE || np_load) begin
      refresh_cnt_reg <= '0;
    end else if (!dirty_reg && refresh_cnt_reg != RW'(REFRESH_CYCLES - 1)) begin
      refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end
`else
  assign refresh_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    np_go      = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!reset && np_ready && !np_load) begin
          if (dirty_reg && (!any_valid || batch_cnt_reg == BATCH_MAX)) state_next = GO;
          else if (refresh_hit) state_next = GO;
        end
      end
      GO: begin
        np_go      = 1'b1;
        busy       = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The controller may still show ready right after go; skip that cycle.
        if (!drain_first_reg && !np_ready) state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (np_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      batch_cnt_reg   <= '0;
      dirty_reg       <= 1'b0;
      rr_ptr_reg      <= PW'(NUM_REQ - 1);
      drain_first_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      drain_first_reg <= (state_reg == GO);
      if (state_reg == GO) begin
        batch_cnt_reg <= '0;
        dirty_reg     <= 1'b0;
      end else if (np_load) begin
        rr_ptr_reg <= grant_idx;
        dirty_reg  <= 1'b1;
        if (batch_cnt_reg != BATCH_MAX) batch_cnt_reg <= batch_cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_np_update_scheduler.sv
// Self-checking bench for np_update_scheduler (default parameters, default build).
module tb_np_update_scheduler;
  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0][2:0] req_pixel;
  logic [1:0][7:0] req_red, req_green, req_blue;
  logic [1:0]      req_ack;
  logic            np_ready, np_load, np_go, busy;
  logic [2:0]      np_pixel;
  logic [7:0]      np_red, np_green, np_blue;

  int n_assert = 0;
  int n_fail   = 0;

  np_update_scheduler dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_pixel(req_pixel),
    .req_red(req_red), .req_green(req_green), .req_blue(req_blue),
    .req_ack(req_ack), .np_ready(np_ready),
    .np_load(np_load), .np_go(np_go), .np_pixel(np_pixel),
    .np_red(np_red), .np_green(np_green), .np_blue(np_blue),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".load"},  32'(np_load),  0);
    chk({name, ".go"},    32'(np_go),    0);
    chk({name, ".ack"},   32'(req_ack),  0);
    chk({name, ".busy"},  32'(busy),     0);
    chk({name, ".pixel"}, 32'(np_pixel), 0);
    chk({name, ".rgb"},   {8'h0, np_red, np_green, np_blue}, 0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; np_ready = 1'b1; req_valid = 2'b11;
    @(negedge clock);
    chk_zero("reset");
    tick(); tick();
    reset = 1'b0; req_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic       ready;
    logic       exp_load;
    logic [1:0] exp_ack;
    logic       exp_go;
    logic       exp_busy;
    logic [2:0] exp_pixel;
    logic [7:0] exp_red;
  } vec_t;
  vec_t tbl[13];

  // Behavioural reference: phase 0 idle, 1 go, 2 drain, 3 wait.
  int   m_phase, m_cnt, m_last, m_dcyc;
  bit   m_dirty;
  logic e_load, e_go, e_busy;
  logic [1:0] e_ack;
  logic [2:0] e_pix;
  logic [7:0] e_r, e_g, e_b;

  task automatic model_step();
    int g;
    int nxt;
    g = -1; nxt = m_phase;
    e_load = 0; e_go = 0; e_busy = 0; e_ack = 0; e_pix = 0; e_r = 0; e_g = 0; e_b = 0;
    if (m_phase == 0) begin
      if (np_ready && m_cnt < 8) begin
        for (int k = 1; k <= 2; k++)
          if (g < 0 && req_valid[(m_last + k) % 2]) g = (m_last + k) % 2;
      end
      if (g >= 0) begin
        e_load = 1; e_ack[g] = 1'b1;
        e_pix = req_pixel[g]; e_r = req_red[g]; e_g = req_green[g]; e_b = req_blue[g];
        m_last = g; m_cnt++; m_dirty = 1;
      end else if (np_ready && m_dirty && (req_valid == 0 || m_cnt == 8)) begin
        nxt = 1;
      end
    end else if (m_phase == 1) begin
      e_go = 1; e_busy = 1; m_cnt = 0; m_dirty = 0; m_dcyc = 0; nxt = 2;
    end else if (m_phase == 2) begin
      e_busy = 1;
      if (m_dcyc > 0 && !np_ready) nxt = 3;
      m_dcyc++;
    end else begin
      e_busy = 1;
      if (np_ready) nxt = 0;
    end
    m_phase = nxt;
  endtask

  initial begin
    int remaining, loads1, loads2, gos, go_cyc;
    logic saw_load;

    req_pixel = '{3'd5, 3'd3};
    req_red   = '{8'd77, 8'd10};
    req_green = '{8'd88, 8'd20};
    req_blue  = '{8'd99, 8'd30};

    //            valid  rdy load ack   go busy pix  red
    tbl[0]  = '{2'b01, 1, 1, 2'b01, 0, 0, 3'd3, 8'd10};
    tbl[1]  = '{2'b00, 1, 0, 2'b00, 0, 0, 3'd0, 8'd0};
    tbl[2]  = '{2'b00, 1, 0, 2'b00, 1, 1, 3'd0, 8'd0};
    tbl[3]  = '{2'b00, 1, 0, 2'b00, 0, 1, 3'd0, 8'd0};
    tbl[4]  = '{2'b00, 0, 0, 2'b00, 0, 1, 3'd0, 8'd0};
    tbl[5]  = '{2'b00, 0, 0, 2'b00, 0, 1, 3'd0, 8'd0};
    tbl[6]  = '{2'b00, 1, 0, 2'b00, 0, 1, 3'd0, 8'd0};
    tbl[7]  = '{2'b11, 1, 1, 2'b10, 0, 0, 3'd5, 8'd77};
    tbl[8]  = '{2'b11, 1, 1, 2'b01, 0, 0, 3'd3, 8'd10};
    tbl[9]  = '{2'b11, 1, 1, 2'b10, 0, 0, 3'd5, 8'd77};
    tbl[10] = '{2'b11, 1, 1, 2'b01, 0, 0, 3'd3, 8'd10};
    tbl[11] = '{2'b00, 1, 0, 2'b00, 0, 0, 3'd0, 8'd0};
    tbl[12] = '{2'b00, 1, 1'b0, 2'b00, 1, 1, 3'd0, 8'd0};

    // Directed table: first load, go pulse, drain/wait, alternating grants.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].valid; np_ready = tbl[i].ready;
      @(negedge clock);
      chk($sformatf("tbl%0d.load", i),  32'(np_load),  32'(tbl[i].exp_load));
      chk($sformatf("tbl%0d.ack", i),   32'(req_ack),  32'(tbl[i].exp_ack));
      chk($sformatf("tbl%0d.go", i),    32'(np_go),    32'(tbl[i].exp_go));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),     32'(tbl[i].exp_busy));
      chk($sformatf("tbl%0d.pixel", i), 32'(np_pixel), 32'(tbl[i].exp_pixel));
      chk($sformatf("tbl%0d.red", i),   32'(np_red),   32'(tbl[i].exp_red));
      $display("tbl %0d: valid=%b ready=%b load=%b ack=%b go=%b busy=%b", i,
               tbl[i].valid, tbl[i].ready, np_load, req_ack, np_go, busy);
      tick();
    end

    // Streaming 10 updates: batch limit forces go after 8, remaining 2 follow.
    do_reset();
    remaining = 10; loads1 = 0; loads2 = 0; gos = 0; go_cyc = -10;
    for (int c = 0; c < 40; c++) begin
      req_valid = {1'b0, remaining > 0};
      np_ready  = (c == go_cyc + 2) ? 1'b0 : 1'b1;
      req_pixel[0] = 3'(remaining);
      @(negedge clock);
      saw_load = np_load;
      if (np_load) begin
        if (gos == 0) loads1++; else loads2++;
      end
      if (np_go) begin
        gos++; go_cyc = c;
        chk("stream.go_no_load", 32'(np_load), 0);
      end
      tick();
      if (saw_load) remaining--;
    end
    chk("stream.first_batch", 32'(loads1), 8);
    chk("stream.second_batch", 32'(loads2), 2);
    chk("stream.go_count", 32'(gos), 2);
    $display("stream: loads %0d + %0d, gos %0d", loads1, loads2, gos);
    req_pixel[0] = 3'd3;

    // Long drain: no load while busy, resume one cycle after ready returns.
    do_reset();
    req_valid = 2'b01; np_ready = 1'b1;
    @(negedge clock); chk("drain.load", 32'(np_load), 1); tick();
    req_valid = 2'b00;
    @(negedge clock); chk("drain.pre_go", 32'(np_go), 0); tick();
    req_valid = 2'b01;
    @(negedge clock); chk("drain.go", 32'(np_go), 1); chk("drain.go_load", 32'(np_load), 0); tick();
    @(negedge clock); chk("drain.first_busy", 32'(busy), 1); chk("drain.first_load", 32'(np_load), 0); tick();
    np_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      chk("drain.hold_busy", 32'(busy), 1);
      chk("drain.hold_load", 32'(np_load), 0);
      tick();
    end
    np_ready = 1'b1;
    @(negedge clock); chk("drain.wait_busy", 32'(busy), 1); chk("drain.wait_load", 32'(np_load), 0); tick();
    @(negedge clock); chk("drain.idle_busy", 32'(busy), 0); chk("drain.resume_ack", 32'(req_ack), 2'b01);
    $display("drain: resumed load=%b ack=%b", np_load, req_ack);
    tick();

    // Reset while draining with pending requests: batch discarded, no go.
    do_reset();
    req_valid = 2'b01; np_ready = 1'b1;
    @(negedge clock); tick();
    req_valid = 2'b00;
    @(negedge clock); tick();
    @(negedge clock); chk("rst.go", 32'(np_go), 1); tick();
    req_valid = 2'b11;
    @(negedge clock); chk("rst.drain_busy", 32'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_zero("rst.async");
    tick(); np_ready = 1'b0;
    @(negedge clock); chk_zero("rst.held");
    tick(); reset = 1'b0;
    @(negedge clock); chk("rst.no_ready_load", 32'(np_load), 0); tick();
    np_ready = 1'b1; req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("rst.no_go", 32'(np_go), 0);
      chk("rst.idle_busy", 32'(busy), 0);
      tick();
    end
    req_valid = 2'b01;
    @(negedge clock); chk("rst.resume_ack", 32'(req_ack), 2'b01);
    $display("reset-in-drain: resume ack=%b", req_ack);
    tick();

`ifndef NPS_AUTO_REFRESH_EN
    // Without auto-refresh an idle clean scheduler never issues go.
    do_reset();
    gos = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (np_go) gos++;
      tick();
    end
    chk("norefresh.go_count", 32'(gos), 0);
    $display("no-refresh idle: gos %0d", gos);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    m_phase = 0; m_cnt = 0; m_last = 1; m_dcyc = 0; m_dirty = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      model_step();
      chk("rand.load",  32'(np_load),  32'(e_load));
      chk("rand.ack",   32'(req_ack),  32'(e_ack));
      chk("rand.go",    32'(np_go),    32'(e_go));
      chk("rand.busy",  32'(busy),     32'(e_busy));
      chk("rand.pixel", 32'(np_pixel), 32'(e_pix));
      chk("rand.rgb",   {8'h0, np_red, np_green, np_blue}, {8'h0, e_r, e_g, e_b});
      tick();
      for (int i = 0; i < 2; i++) begin
        if (e_ack[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_pixel[i] = 3'($urandom);
          req_red[i]   = 8'($urandom);
          req_green[i] = 8'($urandom);
          req_blue[i]  = 8'($urandom);
        end else if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
        end
      end
      np_ready = ($urandom_range(0, 3) != 0);
    end
    $display("random: 3000 cycles compared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
